// File: rtl/mem_bus_slave.sv
// MMU bus target: decodes each request to the fixed-latency SRAM port or the ready-handshake IO port; MEM_BUS_TIMEOUT_EN adds an IO timeout.
// Latency: m_ack RD_LAT+1 / WR_LAT+1 cycles after acceptance (IO: io_rdy+1); one request at a time, m_cyc ignored outside IDLE.
module mem_bus_slave #(
   parameter int          RD_LAT  = 3,
   parameter int          WR_LAT  = 2,
   parameter logic [15:0] IO_PAGE = 16'hFFFF,
   parameter int          TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m_cyc,
   input  logic        m_we,
   input  logic [3:0]  m_strb,
   input  logic [31:0] m_addr,
   input  logic [31:0] m_data_o,
   output logic        m_ack,
   output logic [31:0] m_data_i,
   output logic        mem_ce,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        io_sel,
   output logic        io_we,
   output logic [31:0] io_addr,
   output logic [31:0] io_wdata,
   input  logic [31:0] io_rdata,
   input  logic        io_rdy,
   output logic        bus_err
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_MEM_WAIT = 2'd1;
   localparam logic [1:0] S_IO_WAIT  = 2'd2;
   localparam logic [1:0] S_ACK      = 2'd3;

   localparam logic [3:0] RD_CNT = 4'(RD_LAT);
   localparam logic [3:0] WR_CNT = 4'(WR_LAT);

   generate
      if (RD_LAT < 1 || RD_LAT > 15 || WR_LAT < 1 || WR_LAT > 15) begin : g_bad_lat
         $error("mem_bus_slave: RD_LAT and WR_LAT must be in 1..15");
      end
   endgenerate

   logic [1:0]  r_state;
   logic [3:0]  r_cnt;
   logic        r_we;
   logic [3:0]  r_strb;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic        w_tmo;

`ifdef MEM_BUS_TIMEOUT_EN
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic [TW-1:0] r_tmo;
   logic          r_err;

   // io_rdy in the expiry cycle takes priority, so the timeout is suppressed then.
   assign w_tmo = (r_state == S_IO_WAIT) && !io_rdy && (r_tmo == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tmo <= '0;
         r_err <= 1'b0;
      end else begin
         if (r_state == S_IO_WAIT) r_tmo <= r_tmo + TW'(1);
         else                      r_tmo <= '0;
         if (w_tmo) r_err <= 1'b1;
      end
   end

   assign bus_err = r_err;
`else
   assign w_tmo   = 1'b0;
   assign bus_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_strb  <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (m_cyc) begin
                  r_we    <= m_we;
                  r_strb  <= m_strb;
                  r_addr  <= m_addr;
                  r_wdata <= m_data_o;
                  if (m_addr[31:16] == IO_PAGE) begin
                     r_state <= S_IO_WAIT;
                  end else begin
                     r_state <= S_MEM_WAIT;
                     r_cnt   <= m_we ? WR_CNT : RD_CNT;
                  end
               end
            end
            S_MEM_WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  if (!r_we) r_rdata <= mem_rdata;
                  r_state <= S_ACK;
               end
            end
            S_IO_WAIT: begin
               if (io_rdy) begin
                  if (!r_we) r_rdata <= io_rdata;
                  r_state <= S_ACK;
               end else if (w_tmo) begin
                  r_rdata <= 32'hDEAD_BEEF;
                  r_state <= S_ACK;
               end
            end
            S_ACK: begin
               // Forced idle turnaround lets a burst master present its next address.
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign m_ack     = (r_state == S_ACK);
   assign m_data_i  = r_rdata;
   assign mem_ce    = (r_state == S_MEM_WAIT);
   assign mem_we    = mem_ce & r_we;
   assign mem_be    = mem_ce ? r_strb : 4'b0000;
   assign mem_addr  = r_addr[31:2];
   assign mem_wdata = r_wdata;
   assign io_sel    = (r_state == S_IO_WAIT);
   assign io_we     = io_sel & r_we;
   assign io_addr   = r_addr;
   assign io_wdata  = r_wdata;

endmodule

// File: tb/tb_mem_bus_slave.sv
// Bench for mem_bus_slave: directed table, burst, reset and (with MEM_BUS_TIMEOUT_EN) timeout cases,
// then random traffic against a word-array reference memory and per-request latency rules.
module tb_mem_bus_slave;

   localparam int RD_LAT = 3;
   localparam int WR_LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        m_cyc, m_we;
   logic [3:0]  m_strb;
   logic [31:0] m_addr, m_data_o;
   logic        m_ack;
   logic [31:0] m_data_i;
   logic        mem_ce, mem_we;
   logic [3:0]  mem_be;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        io_sel, io_we;
   logic [31:0] io_addr, io_wdata, io_rdata;
   logic        io_rdy;
   logic        bus_err;

   mem_bus_slave dut (
      .clk(clk), .rst(rst),
      .m_cyc(m_cyc), .m_we(m_we), .m_strb(m_strb), .m_addr(m_addr), .m_data_o(m_data_o),
      .m_ack(m_ack), .m_data_i(m_data_i),
      .mem_ce(mem_ce), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .io_sel(io_sel), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
      .io_rdata(io_rdata), .io_rdy(io_rdy), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] dflt(input logic [11:0] w);
      return ({20'b0, w} + 32'd1) * 32'h9E37_79B9;
   endfunction

   // SRAM device: unwritten words read back a fixed address-derived pattern.
   logic [31:0] sram   [0:4095];
   bit          sram_v [0:4095];
   always @(posedge clk) begin
      if (mem_ce && mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) sram[mem_addr[11:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
         if (!sram_v[mem_addr[11:0]]) begin
            for (int b = 0; b < 4; b++)
               if (!mem_be[b]) sram[mem_addr[11:0]][8*b +: 8] <= dflt(mem_addr[11:0]) >> (8*b);
            sram_v[mem_addr[11:0]] <= 1'b1;
         end
      end
   end
   assign mem_rdata = mem_ce ? (sram_v[mem_addr[11:0]] ? sram[mem_addr[11:0]] : dflt(mem_addr[11:0]))
                             : 32'h0BAD_0BAD;

   // IO device: answers in the io_dly-th cycle of io_sel (0 = never); noise on io_rdy when idle.
   int          io_dly = 1;
   logic [31:0] io_val = 32'h0;
   int          io_seen;
   bit          spur;
   always @(negedge clk) spur <= 1'($urandom_range(0, 1));
   always @(posedge clk or posedge rst) begin
      if (rst)                    io_seen <= 0;
      else if (io_sel && !io_rdy) io_seen <= io_seen + 1;
      else                        io_seen <= 0;
   end
   assign io_rdy   = io_sel ? (io_dly != 0 && io_seen == io_dly - 1) : spur;
   assign io_rdata = (io_sel && io_rdy) ? io_val : 32'hFACE_FACE;

   logic any_out;
   assign any_out = |{m_ack, m_data_i, mem_ce, mem_we, mem_be, mem_addr, mem_wdata,
                      io_sel, io_we, io_addr, io_wdata, bus_err};

   logic [31:0] ref_mem [0:4095];
   logic [31:0] exp_mdata;

   task automatic ref_write(input logic [11:0] w, input logic [3:0] be, input logic [31:0] d);
      for (int b = 0; b < 4; b++)
         if (be[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One request from the cycle after the call; returns in the ack cycle (or after 200 cycles).
   task automatic run_txn(input logic we, input logic [3:0] strb, input logic [31:0] addr,
                          input logic [31:0] data, input bit hold,
                          output int lat, output int ce_n, output int io_n, output int bad,
                          output logic [31:0] rd);
      @(posedge clk); #1;
      m_cyc = 1'b1; m_we = we; m_strb = strb; m_addr = addr; m_data_o = data;
      lat = 0; ce_n = 0; io_n = 0; bad = 0;
      do begin
         @(posedge clk); #1;
         if (!hold) m_cyc = 1'b0;
         lat++;
         if (mem_ce) begin
            ce_n++;
            if (mem_addr !== addr[31:2] || mem_we !== we || mem_be !== strb || mem_wdata !== data) bad++;
         end
         if (io_sel) begin
            io_n++;
            if (io_addr !== addr || io_we !== we || io_wdata !== data) bad++;
         end
      end while (!m_ack && lat < 200);
      rd = m_data_i;
   endtask

   typedef struct {
      logic        we;
      logic [3:0]  strb;
      logic [31:0] addr;
      logic [31:0] data;
      int          io_dly;
      logic [31:0] io_val;
      int          exp_lat;
      int          exp_ce;
      int          exp_io;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t        tbl [7];
   int          lat, ce_n, io_n, bad, acks;
   int          t_prev;
   logic [31:0] rd, t801, addr, data, exp_rd;
   logic [3:0]  strb;
   logic        we;
   bit          is_io, hold;

   initial begin
      for (int i = 0; i < 4096; i++) begin
         ref_mem[i] = dflt(12'(i));
         sram_v[i]  = 1'b0;
      end
      t801 = dflt(12'h801);
      tbl[0] = '{1'b1, 4'hF,    32'h0000_1000, 32'h1234_5678, 1, 32'h0,         3, 2, 0, 32'h0};
      tbl[1] = '{1'b0, 4'hF,    32'h0000_1000, 32'h0,         1, 32'h0,         4, 3, 0, 32'h1234_5678};
      tbl[2] = '{1'b1, 4'b0011, 32'h0000_2004, 32'hA5A5_A5A5, 1, 32'h0,         3, 2, 0, 32'h1234_5678};
      tbl[3] = '{1'b0, 4'hF,    32'h0000_2004, 32'h0,         1, 32'h0,         4, 3, 0, {t801[31:16], 16'hA5A5}};
      tbl[4] = '{1'b0, 4'hF,    32'hFFFF_0010, 32'h0,         5, 32'h0000_00FF, 6, 0, 5, 32'h0000_00FF};
      tbl[5] = '{1'b1, 4'hF,    32'hFFFF_0022, 32'hCAFE_F00D, 1, 32'h0,         2, 0, 1, 32'h0000_00FF};
      tbl[6] = '{1'b0, 4'h0,    32'h0000_0FFE, 32'h0,         1, 32'h0,         4, 3, 0, dflt(12'h3FF)};

      rst = 1'b1; m_cyc = 1'b0; m_we = 1'b0; m_strb = 4'h0; m_addr = 32'h0; m_data_o = 32'h0;
      #12;
      check("reset_outputs_zero", 32'(any_out), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("idle_no_ack", 32'(m_ack), 32'h0);

      for (int i = 0; i < 7; i++) begin
         io_dly = tbl[i].io_dly;
         io_val = tbl[i].io_val;
         run_txn(tbl[i].we, tbl[i].strb, tbl[i].addr, tbl[i].data, 1'b0, lat, ce_n, io_n, bad, rd);
         check($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
         check($sformatf("vec%0d_mem_ce_cycles", i), ce_n, tbl[i].exp_ce);
         check($sformatf("vec%0d_io_sel_cycles", i), io_n, tbl[i].exp_io);
         check($sformatf("vec%0d_port_signals", i), bad, 0);
         check($sformatf("vec%0d_m_data_i", i), rd, tbl[i].exp_rd);
         if (tbl[i].we && tbl[i].addr[31:16] != 16'hFFFF)
            ref_write(tbl[i].addr[13:2], tbl[i].strb, tbl[i].data);
      end
      exp_mdata = dflt(12'h3FF);

      // 8-beat line burst with m_cyc held high throughout.
      t_prev = 0;
      for (int i = 0; i < 8; i++) begin
         addr = 32'h0000_3000 + 32'(4 * i);
         run_txn(1'b0, 4'hF, addr, 32'h0, 1'b1, lat, ce_n, io_n, bad, rd);
         check($sformatf("burst%0d_latency", i), lat, RD_LAT + 1);
         check($sformatf("burst%0d_data", i), rd, ref_mem[addr[13:2]]);
         check($sformatf("burst%0d_mem_addr", i), bad, 0);
         if (i > 0) check($sformatf("burst%0d_ack_spacing", i), cyc - t_prev, 5);
         t_prev = cyc;
         exp_mdata = rd;
      end
      m_cyc = 1'b0;
      exp_mdata = ref_mem[12'hC07];

      for (int n = 0; n < 40; n++) begin
         is_io  = ($urandom_range(0, 3) == 0);
         we     = 1'($urandom_range(0, 1));
         strb   = 4'($urandom);
         data   = $urandom;
         hold   = 1'($urandom_range(0, 1));
         io_dly = $urandom_range(1, 8);
         io_val = $urandom;
         addr   = is_io ? {16'hFFFF, 16'($urandom)} : {18'b0, 14'($urandom)};
         run_txn(we, strb, addr, data, hold, lat, ce_n, io_n, bad, rd);
         m_cyc = 1'b0;
         if (we)         exp_rd = exp_mdata;
         else if (is_io) exp_rd = io_val;
         else            exp_rd = ref_mem[addr[13:2]];
         check($sformatf("rand%0d_latency", n), lat,
               is_io ? io_dly + 1 : (we ? WR_LAT + 1 : RD_LAT + 1));
         check($sformatf("rand%0d_m_data_i", n), rd, exp_rd);
         exp_mdata = exp_rd;
         if (we && !is_io) ref_write(addr[13:2], strb, data);
      end

      // Reset in the middle of a memory read's wait states.
      @(posedge clk); #1;
      m_cyc = 1'b1; m_we = 1'b0; m_strb = 4'hF; m_addr = 32'h0000_1000;
      @(posedge clk); #1;
      m_cyc = 1'b0;
      @(posedge clk); #1;
      check("pre_reset_mem_ce", 32'(mem_ce), 32'h1);
      #2 rst = 1'b1;
      #1 check("async_reset_outputs_zero", 32'(any_out), 32'h0);
      acks = 0;
      repeat (2) begin @(posedge clk); #1; acks += int'(m_ack); end
      rst = 1'b0;
      repeat (5) begin @(posedge clk); #1; acks += int'(m_ack); end
      check("no_ack_after_abort", acks, 0);
      run_txn(1'b0, 4'hF, 32'h0000_1000, 32'h0, 1'b0, lat, ce_n, io_n, bad, rd);
      check("post_reset_latency", lat, RD_LAT + 1);
      check("post_reset_data", rd, 32'h1234_5678);

`ifdef MEM_BUS_TIMEOUT_EN
      io_dly = 64; io_val = 32'h7777_0001;
      run_txn(1'b0, 4'hF, 32'hFFFF_0100, 32'h0, 1'b0, lat, ce_n, io_n, bad, rd);
      check("tmo_tie_latency", lat, 65);
      check("tmo_tie_data", rd, 32'h7777_0001);
      check("tmo_tie_bus_err", 32'(bus_err), 32'h0);
      io_dly = 0;
      run_txn(1'b0, 4'hF, 32'hFFFF_0104, 32'h0, 1'b0, lat, ce_n, io_n, bad, rd);
      check("tmo_latency", lat, 65);
      check("tmo_io_sel_cycles", io_n, 64);
      check("tmo_data", rd, 32'hDEAD_BEEF);
      check("tmo_bus_err_set", 32'(bus_err), 32'h1);
      run_txn(1'b0, 4'hF, 32'h0000_1000, 32'h0, 1'b0, lat, ce_n, io_n, bad, rd);
      check("tmo_bus_err_sticky", 32'(bus_err), 32'h1);
      check("tmo_then_mem_data", rd, 32'h1234_5678);
      rst = 1'b1;
      #1 check("tmo_bus_err_cleared", 32'(bus_err), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
`endif

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_bus_slave.md
Name: mem_bus_slave

Overview:
Bus target that sits directly downstream of the CPU memory-management unit's master port (m_cyc/m_we/m_strb/m_addr/m_data_o in, m_ack/m_data_i out). It decodes each request to either the main-memory SRAM port, which has fixed wait states, or the IO device port, which uses a ready handshake. It then returns a single-cycle m_ack with registered read data. It must accept the MMU's back-to-back 4- and 8-word line bursts, where m_cyc stays high and the address advances one cycle after each ack.

Parameters:
RD_LAT, 3, memory read wait cycles (legal 1..15)
WR_LAT, 2, memory write wait cycles (legal 1..15)
IO_PAGE, 16'hFFFF, m_addr[31:16] value that selects the IO port
TIMEOUT, 64, IO ready timeout in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
m_cyc  in  1  request valid from MMU
m_we  in  1  1=write, 0=read
m_strb  in  4  byte enables
m_addr  in  32  byte address (bits [1:0] ignored)
m_data_o  in  32  write data from MMU
m_ack  out  1  one-cycle completion pulse
m_data_i  out  32  read data to MMU, valid while m_ack=1
mem_ce  out  1  SRAM chip enable
mem_we  out  1  SRAM write enable
mem_be  out  4  SRAM byte enables
mem_addr  out  30  SRAM word address
mem_wdata  out  32  SRAM write data
mem_rdata  in  32  SRAM read data
io_sel  out  1  IO request, held high until io_rdy
io_we  out  1  IO write
io_addr  out  32  IO address
io_wdata  out  32  IO write data
io_rdata  in  32  IO read data, valid with io_rdy
io_rdy  in  1  IO completion
bus_err  out  1  sticky IO timeout flag

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All outputs are 0, including m_data_i, mem_addr, io_addr and bus_err.
  - An in-flight transfer is abandoned and no ack is issued.
- State machine: IDLE, MEM_WAIT, IO_WAIT, ACK.
- IDLE:
  - When m_cyc=1, latch m_we, m_strb, m_addr and m_data_o into request registers.
  - If req_addr[31:16]==IO_PAGE, go to IO_WAIT; otherwise go to MEM_WAIT and load cnt = m_we ? WR_LAT : RD_LAT.
- MEM_WAIT:
  - Drive mem_ce=1, mem_we=req_we, mem_be=req_strb, mem_addr=req_addr[31:2] and mem_wdata=req_data, all from registers.
  - cnt decrements each cycle.
  - In the cycle where cnt==1: on a read, capture mem_rdata into the data register; then go to ACK.
  - Read latency from the m_cyc sample cycle to m_ack is RD_LAT+1 cycles; write latency is WR_LAT+1 cycles.
- IO_WAIT:
  - Drive io_sel=1, io_we=req_we, io_addr=req_addr and io_wdata=req_data.
  - On io_rdy=1: on a read, capture io_rdata; then go to ACK.
  - io_rdy is ignored while io_sel=0.
- ACK:
  - m_ack=1 for exactly one cycle; mem_ce=0 and io_sel=0.
  - The next state is always IDLE.
  - The IDLE cycle that follows samples the MMU's incremented address, so there is exactly one idle turnaround between burst beats.
- m_data_i is registered:
  - It holds its last value between acks.
  - Writes do not modify it.
- m_cyc is not checked after acceptance. If it drops mid-transfer, the transfer still completes and acks.
- m_cyc=1 arriving in ACK is not accepted until the following IDLE.
- cnt is 4 bits. RD_LAT or WR_LAT = 0 is illegal; flag it with a simulation-time check.
- There is never more than one outstanding request, so simultaneous memory and IO activity cannot occur.

Optional Feature:
- Macro: MEM_BUS_TIMEOUT_EN.
- When defined:
  - A counter runs while in IO_WAIT.
  - If io_rdy has not arrived after TIMEOUT cycles, go to ACK with m_data_i=32'hDEAD_BEEF and set bus_err=1.
  - bus_err is sticky and cleared only by rst.
  - io_rdy arriving in the same cycle as the timeout wins, i.e. it is a normal completion.
- When undefined:
  - IO_WAIT waits indefinitely.
  - bus_err is tied to 0 and no counter is instantiated.

Test Plan:
- Read 0x0000_1000 with RD_LAT=3 and mem_rdata=32'h1234_5678 -> mem_ce high for cycles 1-3, mem_addr=30'h400, m_ack in cycle 4 with m_data_i=32'h1234_5678.
- Write 0x0000_2004, data 32'hA5A5_A5A5, strb 4'b0011, WR_LAT=2 -> mem_we=1 and mem_be=4'b0011 for 2 cycles, m_ack in cycle 3, m_data_i unchanged.
- 8-beat burst from 0x0000_3000, m_cyc held high, address +4 one cycle after each ack -> 8 acks spaced 5 cycles apart, mem_addr 30'hC00..30'hC07 in order, each beat's data correct.
- IO read 0xFFFF_0010 with io_rdy after 5 cycles and io_rdata=32'h0000_00FF -> io_sel high for 5 cycles, m_ack the cycle after io_rdy, m_data_i=32'h0000_00FF.
- Assert rst during MEM_WAIT of a read -> all outputs 0 immediately; no m_ack; next m_cyc after rst deasserts is serviced normally.
- With MEM_BUS_TIMEOUT_EN and TIMEOUT=64, IO read with io_rdy never asserted -> m_ack after 64 IO_WAIT cycles, m_data_i=32'hDEAD_BEEF, bus_err=1 and stays high until rst.
